serial_subtractor: RTL and testbench

Parametrised bit-serial subtractor: computes `a - b` for two WIDTH-bit operands, one bit per clock, LSB first, using a half-subtractor cell extended with a registered borrow. It generalises the single-bit half subtractor to arbitrary width. It adds a start/busy/done handshake and unsigned-borrow and signed-overflow flags. It is the area-minimal arithmetic option for control paths where WIDTH-cycle latency is acceptable.

---
 rtl/serial_subtractor.sv | 90 +++++++++
 tb/tb_serial_subtractor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first: one half-subtractor step per clock with a registered borrow.
// WIDTH cycles from accepted start to a one-cycle done pulse; start is ignored while busy.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bor,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt;
  logic [CW-1:0]    cnt;
  logic             br, a_msb, b_msb;
  logic             x, y, d, br_nxt;

  assign x      = a_sh[0];
  assign y      = b_sh[0];
  assign d      = x ^ y ^ br;
  assign br_nxt = (~x & y) | (~(x ^ y) & br);
  assign diff   = res;

  // New bit enters at the MSB so the result is right-aligned after WIDTH shifts.
  always_comb begin
    res_nxt            = res >> 1;
    res_nxt[WIDTH-1]   = d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bor   <= 1'b0;
      ovf   <= 1'b0;
      res   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= res_nxt;
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            bor   <= br_nxt;
            // d is the final result MSB on this step
            ovf   <= (a_msb != b_msb) & (d != a_msb);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH = 1, 8 and 16.
module tb_serial_subtractor;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        rst_n, rst16;
  logic        start1, start8, start16;
  logic [0:0]  a1, b1, diff1;
  logic [7:0]  a8, b8, diff8;
  logic [15:0] a16, b16, diff16;
  logic        busy1, done1, bor1, ovf1;
  logic        busy8, done8, bor8, ovf8;
  logic        busy16, done16, bor16, ovf16;

  serial_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .bor(bor1), .ovf(ovf1));
  serial_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bor(bor8), .ovf(ovf8));
  serial_subtractor #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst16), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .bor(bor16), .ovf(ovf16));

  typedef struct {
    logic [15:0] diff;
    logic        bor;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q1[$], q8[$], q16[$];
  exp_t e1, e8, e16;
  logic pd1 = 1'b0, pd8 = 1'b0, pd16 = 1'b0;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] d, input logic br, input logic ov, input int done_cyc);
    exp_t e;
    e.diff = d;
    e.bor  = br;
    e.ovf  = ov;
    e.cyc  = done_cyc;
    return e;
  endfunction

  // Monitors sample on the falling edge; expected done time is stored with each entry.
  always @(negedge clk) begin
    if (pd1) check("w1_done_pulse", done1, 0);
    if (done1) begin
      if (q1.size() == 0) check("w1_spurious_done", done1, 0);
      else begin
        e1 = q1.pop_front();
        check("w1_diff", diff1, e1.diff);
        check("w1_bor", bor1, e1.bor);
        check("w1_ovf", ovf1, e1.ovf);
        check("w1_latency", cyc, e1.cyc);
      end
    end
    pd1 = done1;
  end

  always @(negedge clk) begin
    if (pd8) check("w8_done_pulse", done8, 0);
    if (done8) begin
      if (q8.size() == 0) check("w8_spurious_done", done8, 0);
      else begin
        e8 = q8.pop_front();
        check("w8_diff", diff8, e8.diff);
        check("w8_bor", bor8, e8.bor);
        check("w8_ovf", ovf8, e8.ovf);
        check("w8_latency", cyc, e8.cyc);
        check("w8_busy_in_done", busy8, 0);
      end
    end
    pd8 = done8;
  end

  always @(negedge clk) begin
    if (pd16) check("w16_done_pulse", done16, 0);
    if (done16) begin
      if (q16.size() == 0) check("w16_spurious_done", done16, 0);
      else begin
        e16 = q16.pop_front();
        check("w16_diff", diff16, e16.diff);
        check("w16_bor", bor16, e16.bor);
        check("w16_ovf", ovf16, e16.ovf);
        check("w16_latency", cyc, e16.cyc);
      end
    end
    pd16 = done16;
  end

  // Callers are positioned #1 after a rising edge; start is taken at the next edge.
  task automatic go1(input logic a, input logic b, input logic ed, input logic eb, input logic eo);
    a1 = a; b1 = b; start1 = 1'b1;
    q1.push_back(mk(16'(ed), eb, eo, cyc + 1 + 1));
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ed, input logic eb, input logic eo);
    a8 = a; b8 = b; start8 = 1'b1;
    q8.push_back(mk(16'(ed), eb, eo, cyc + 1 + 8));
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic go16(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] ed, input logic eb, input logic eo);
    a16 = a; b16 = b; start16 = 1'b1;
    q16.push_back(mk(ed, eb, eo, cyc + 1 + 16));
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  task automatic drain(input int which);
    for (int i = 0; i < 200; i++) begin
      if (which == 1 && q1.size() == 0) break;
      if (which == 8 && q8.size() == 0) break;
      if (which == 16 && q16.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk); #1;
    case (which)
      1:       check("w1_drain", q1.size(), 0);
      8:       check("w8_drain", q8.size(), 0);
      default: check("w16_drain", q16.size(), 0);
    endcase
  endtask

  initial begin
    logic [7:0] ra, rb;
    int         sd;
    logic [1:0] ab;
    logic [1:0] t_diff, t_bor, t_ovf;

    rst_n = 1'b0; rst16 = 1'b0;
    start1 = 1'b0; start8 = 1'b0; start16 = 1'b0;
    a1 = '0; b1 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_diff8", diff8, 0);
    check("rst_bor8", bor8, 0);
    check("rst_ovf8", ovf8, 0);
    check("rst_busy16", busy16, 0);
    check("rst_diff1", diff1, 0);
    rst_n = 1'b1; rst16 = 1'b1;
    @(posedge clk); #1;

    // WIDTH=1 half-subtractor truth table, (a,b) = 00,01,10,11
    t_diff = 2'b00; t_bor = 2'b00; t_ovf = 2'b00;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      case (i)
        0: begin t_diff[0] = 1'b0; t_bor[0] = 1'b0; t_ovf[0] = 1'b0; end
        1: begin t_diff[0] = 1'b1; t_bor[0] = 1'b1; t_ovf[0] = 1'b1; end
        2: begin t_diff[0] = 1'b1; t_bor[0] = 1'b0; t_ovf[0] = 1'b0; end
        default: begin t_diff[0] = 1'b0; t_bor[0] = 1'b0; t_ovf[0] = 1'b0; end
      endcase
      go1(ab[1], ab[0], t_diff[0], t_bor[0], t_ovf[0]);
      drain(1);
    end

    go8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    check("w8_busy_run", busy8, 1);
    drain(8);
    go8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    drain(8);
    go8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    drain(8);

    // Back-to-back: restart in the DONE cycle
    go8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    for (int i = 0; i < 50 && !done8; i++) begin
      @(posedge clk); #1;
    end
    check("w8_b2b_done_seen", done8, 1);
    go8(8'h10, 8'h10, 8'h00, 1'b0, 1'b0);
    check("w8_b2b_busy", busy8, 1);
    drain(8);

    // Start during RUN must be ignored and a/b not resampled
    go8(8'h20, 8'h01, 8'h1F, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("w8_busy_ignored_start", busy8, 1);
    drain(8);

    // Arithmetic reference for random operands
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      sd = int'($signed(ra)) - int'($signed(rb));
      go8(ra, rb, 8'(ra - rb), (ra < rb), (sd > 127 || sd < -128));
      drain(8);
    end

    // Reset mid-RUN aborts with no done
    a16 = 16'h0000; b16 = 16'h0001; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("w16_busy_before_rst", busy16, 1);
    rst16 = 1'b0;
    @(posedge clk); #1;
    rst16 = 1'b1;
    check("w16_rst_busy", busy16, 0);
    check("w16_rst_done", done16, 0);
    check("w16_rst_diff", diff16, 0);
    check("w16_rst_bor", bor16, 0);
    check("w16_rst_ovf", ovf16, 0);
    repeat (20) @(posedge clk);
    #1;
    go16(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
    drain(16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
